fp_add_arbiter: RTL and testbench

- Round-robin arbiter/sequencer that shares one floating-point adder (1 sign, 6 exponent, 25 mantissa bits) among NUM_REQ requesters.
- Per job: accepts one operand pair, issues it to the adder with a start pulse, waits for done or timeout, and returns result and status to the owning requester.
- Sits between the client blocks and the single adder instance.

---
 rtl/fp_add_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_fp_add_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_arbiter.sv
// Round-robin sequencer sharing one FP adder among NUM_REQ requesters.
// Optional FP_ARB_ZERO_BYPASS_EN: jobs with a zero operand skip the adder.
//
// state | meaning
// IDLE  | waiting for any req_valid, arbitrate and capture operands
// ISSUE | fpu_start pulse, load the WAIT timer
// WAIT  | waiting for fpu_done or timer terminal count
// RESP  | resp_valid pulse to the owner, update last_grant
module fp_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64,
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clock_100kHz,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_op_a,
  input  logic [32*NUM_REQ-1:0]  req_op_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic [31:0]            resp_data,
  output logic [3:0]             resp_status,
  output logic [GW-1:0]          grant_id,
  output logic                   busy,
  output logic                   fpu_start,
  output logic [31:0]            fpu_op_a,
  output logic [31:0]            fpu_op_b,
  input  logic                   fpu_done,
  input  logic [31:0]            fpu_result,
  input  logic [3:0]             fpu_status
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [3:0] ST_TIMEOUT = 4'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [GW-1:0]      last_grant_q, last_grant_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [31:0]        op_a_q, op_a_d;
  logic [31:0]        op_b_q, op_b_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
  logic [31:0]        resp_data_q, resp_data_d;
  logic [3:0]         resp_status_q, resp_status_d;

  logic               pick_found;
  logic [GW-1:0]      pick_idx;
  logic [GW-1:0]      cand;
  logic [31:0]        sel_a;
  logic [31:0]        sel_b;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [GW-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (idx == GW'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Search starts just after the last grant; the modulo keeps non-power-of-two counts in range.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((int'(last_grant_q) + k) % NUM_REQ);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == GW'(i)) begin
        sel_a = req_op_a[32*i +: 32];
        sel_b = req_op_b[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_d       = grant_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    timer_d       = timer_q;
    req_ready_d   = '0;
    resp_valid_d  = '0;
    resp_data_d   = resp_data_q;
    resp_status_d = resp_status_q;

    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_d     = pick_idx;
          op_a_d      = sel_a;
          op_b_d      = sel_b;
          req_ready_d = onehot(pick_idx);
          state_d     = S_ISSUE;
`ifdef FP_ARB_ZERO_BYPASS_EN
          // A zero operand (either sign) makes the sum the other operand, exactly.
          if ((sel_a[30:0] == 31'd0) || (sel_b[30:0] == 31'd0)) begin
            resp_valid_d  = onehot(pick_idx);
            resp_data_d   = (sel_b[30:0] == 31'd0) ? sel_a : sel_b;
            resp_status_d = 4'd0;
            state_d       = S_RESP;
          end
`endif
        end
      end

      S_ISSUE: begin
        timer_d = TW'(TIMEOUT - 1);
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (fpu_done) begin
          resp_data_d   = fpu_result;
          resp_status_d = fpu_status;
          resp_valid_d  = onehot(grant_q);
          state_d       = S_RESP;
        end else if (timer_q == '0) begin
          resp_data_d   = '0;
          resp_status_d = ST_TIMEOUT;
          resp_valid_d  = onehot(grant_q);
          state_d       = S_RESP;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      S_RESP: begin
        last_grant_d = grant_q;
        state_d      = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_100kHz or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      last_grant_q  <= GW'(NUM_REQ - 1);
      grant_q       <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      timer_q       <= '0;
      req_ready_q   <= '0;
      resp_valid_q  <= '0;
      resp_data_q   <= '0;
      resp_status_q <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_q       <= grant_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      timer_q       <= timer_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
      resp_status_q <= resp_status_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign resp_status = resp_status_q;
  assign grant_id    = grant_q;
  assign busy        = (state_q != S_IDLE);
  assign fpu_start   = (state_q == S_ISSUE);
  assign fpu_op_a    = op_a_q;
  assign fpu_op_b    = op_b_q;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter: a 4-requester instance plus a 3-requester
// instance for non-power-of-two wrap.
`timescale 1ns/1ps
module tb_fp_add_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]   req_valid;
  logic [127:0] req_op_a, req_op_b;
  logic [3:0]   req_ready, resp_valid;
  logic [31:0]  resp_data;
  logic [3:0]   resp_status;
  logic [1:0]   grant_id;
  logic         busy, fpu_start;
  logic [31:0]  fpu_op_a, fpu_op_b;
  logic         fpu_done;
  logic [31:0]  fpu_result;
  logic [3:0]   fpu_status;

  logic [2:0]   r3_valid;
  logic [95:0]  r3_op_a, r3_op_b;
  logic [2:0]   r3_ready, r3_resp_valid;
  logic [31:0]  r3_resp_data;
  logic [3:0]   r3_resp_status;
  logic [1:0]   r3_grant;
  logic         r3_busy, r3_start;
  logic [31:0]  r3_fpu_a, r3_fpu_b;
  logic         r3_done;
  logic [31:0]  r3_result;
  logic [3:0]   r3_status;

  int n_pass = 0;
  int n_chk  = 0;
  logic [3:0] seen_ready;

  fp_add_arbiter #(.NUM_REQ(4), .TIMEOUT(64)) dut (
    .clock_100kHz(clk), .reset(rst),
    .req_valid(req_valid), .req_op_a(req_op_a), .req_op_b(req_op_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_status(resp_status), .grant_id(grant_id), .busy(busy),
    .fpu_start(fpu_start), .fpu_op_a(fpu_op_a), .fpu_op_b(fpu_op_b),
    .fpu_done(fpu_done), .fpu_result(fpu_result), .fpu_status(fpu_status)
  );

  fp_add_arbiter #(.NUM_REQ(3), .TIMEOUT(8)) dut3 (
    .clock_100kHz(clk), .reset(rst),
    .req_valid(r3_valid), .req_op_a(r3_op_a), .req_op_b(r3_op_b),
    .req_ready(r3_ready), .resp_valid(r3_resp_valid), .resp_data(r3_resp_data),
    .resp_status(r3_resp_status), .grant_id(r3_grant), .busy(r3_busy),
    .fpu_start(r3_start), .fpu_op_a(r3_fpu_a), .fpu_op_b(r3_fpu_b),
    .fpu_done(r3_done), .fpu_result(r3_result), .fpu_status(r3_status)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Caller presents the request in IDLE; done is pulsed in WAIT cycle 'lat'.
  task automatic job4(input string tag, input int g, input logic [31:0] ea,
                      input logic [31:0] eb, input int lat, input logic [31:0] res,
                      input logic [3:0] st, input bit drop);
    tick();
    seen_ready = req_ready;
    chk({tag, "_ready"}, {28'd0, req_ready}, 32'd1 << g);
    chk({tag, "_grant"}, {30'd0, grant_id}, g);
    chk({tag, "_start"}, {31'd0, fpu_start}, 32'd1);
    chk({tag, "_op_a"}, fpu_op_a, ea);
    chk({tag, "_op_b"}, fpu_op_b, eb);
    if (drop) req_valid = req_valid & ~req_ready;
    for (int i = 0; i < lat; i++) begin
      tick();
      if (i == 0) chk({tag, "_start_off"}, {31'd0, fpu_start}, 32'd0);
    end
    fpu_done = 1'b1; fpu_result = res; fpu_status = st;
    tick();
    fpu_done = 1'b0;
    chk({tag, "_resp_valid"}, {28'd0, resp_valid}, 32'd1 << g);
    chk({tag, "_resp_data"}, resp_data, res);
    chk({tag, "_resp_status"}, {28'd0, resp_status}, {28'd0, st});
    tick();
    chk({tag, "_resp_clear"}, {28'd0, resp_valid}, 32'd0);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic job3(input string tag, input int g, input logic [31:0] res, input bit drop);
    tick();
    chk({tag, "_ready"}, {29'd0, r3_ready}, 32'd1 << g);
    chk({tag, "_grant"}, {30'd0, r3_grant}, g);
    chk({tag, "_op_a"}, r3_fpu_a, 32'hC000_0000 + g);
    if (drop) r3_valid = r3_valid & ~r3_ready;
    tick();
    r3_done = 1'b1; r3_result = res; r3_status = 4'd0;
    tick();
    r3_done = 1'b0;
    chk({tag, "_resp_valid"}, {29'd0, r3_resp_valid}, 32'd1 << g);
    chk({tag, "_resp_data"}, r3_resp_data, res);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rr_cnt [4];
    int n;
    bit found;
    logic [3:0] acc;

    req_valid = '0; req_op_a = '0; req_op_b = '0;
    fpu_done = 1'b0; fpu_result = '0; fpu_status = '0;
    r3_valid = '0; r3_op_a = '0; r3_op_b = '0;
    r3_done = 1'b0; r3_result = '0; r3_status = '0;

    // reset state
    rst = 1'b1;
    tick(); tick();
    chk("rst_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {28'd0, resp_valid}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_grant", {30'd0, grant_id}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_start", {31'd0, fpu_start}, 32'd0);
    rst = 1'b0;

    // single job
    req_valid = 4'b0001;
    req_op_a[31:0] = 32'h0400_0000;
    req_op_b[31:0] = 32'h0400_0000;
    job4("single", 0, 32'h0400_0000, 32'h0400_0000, 3, 32'h0600_0000, 4'd0, 1'b1);
    tick();
    chk("single_busy_after", {31'd0, busy}, 32'd0);

    // round-robin with all four held
    rst = 1'b1; tick(); rst = 1'b0;
    req_op_a = {32'h3F00_0003, 32'h3F00_0002, 32'h3F00_0001, 32'h3F00_0000};
    req_op_b = {32'h4000_0003, 32'h4000_0002, 32'h4000_0001, 32'h4000_0000};
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) rr_cnt[i] = 0;
    for (int j = 0; j < 5; j++) begin
      job4("rr", j % 4, 32'h3F00_0000 + (j % 4), 32'h4000_0000 + (j % 4), 1,
           32'h5000_0000 + j, 4'd0, 1'b0);
      if (j < 4) begin
        for (int i = 0; i < 4; i++) rr_cnt[i] += int'(seen_ready[i]);
      end
    end
    req_valid = '0;
    for (int i = 0; i < 4; i++) chk("rr_one_per_round", rr_cnt[i], 32'd1);

    // skip and wrap, NUM_REQ=4
    rst = 1'b1; tick(); rst = 1'b0;
    req_valid = 4'b0100;
    job4("sw_g2", 2, 32'h3F00_0002, 32'h4000_0002, 2, 32'h6100_0000, 4'd1, 1'b1);
    req_valid = 4'b0011;
    job4("sw_g0", 0, 32'h3F00_0000, 32'h4000_0000, 1, 32'h6200_0000, 4'd2, 1'b1);
    job4("sw_g1", 1, 32'h3F00_0001, 32'h4000_0001, 1, 32'h6300_0000, 4'd3, 1'b1);
    req_valid = '0;

    // wrap with NUM_REQ=3
    r3_op_a = {32'hC000_0002, 32'hC000_0001, 32'hC000_0000};
    r3_op_b = {32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
    r3_valid = 3'b100;
    job3("w3_g2", 2, 32'h7000_0001, 1'b1);
    r3_valid = 3'b101;
    job3("w3_g0", 0, 32'h7000_0002, 1'b0);
    job3("w3_g2b", 2, 32'h7000_0003, 1'b0);
    job3("w3_g0b", 0, 32'h7000_0004, 1'b1);
    r3_valid = '0;

    // timeout: count WAIT cycles until the response
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    chk("to_start", {31'd0, fpu_start}, 32'd1);
    n = 0; found = 1'b0;
    while (!found && n < 100) begin
      tick();
      n++;
      if (resp_valid != 4'd0) found = 1'b1;
    end
    chk("to_wait_cycles", n - 1, 32'd64);
    chk("to_resp_valid", {28'd0, resp_valid}, 32'd1);
    chk("to_resp_data", resp_data, 32'd0);
    chk("to_resp_status", {28'd0, resp_status}, 32'd4);
    tick();
    fpu_done = 1'b1; fpu_result = 32'hDEAD_BEEF; fpu_status = 4'd3;
    tick();
    fpu_done = 1'b0;
    acc = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      acc |= resp_valid;
    end
    chk("late_done_resp", {28'd0, acc}, 32'd0);
    chk("late_done_data", resp_data, 32'd0);
    chk("late_done_busy", {31'd0, busy}, 32'd0);

    // done in the same cycle as the timeout
    req_valid = 4'b0001;
    job4("coll", 0, 32'h3F00_0000, 32'h4000_0000, 64, 32'h1234_5678, 4'd3, 1'b1);

    // reset during WAIT, requester 0 still pending
    req_valid = 4'b0011;
    tick();
    chk("mid_grant", {30'd0, grant_id}, 32'd1);
    tick(); tick();
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mr_ready", {28'd0, req_ready}, 32'd0);
    chk("mr_resp_valid", {28'd0, resp_valid}, 32'd0);
    chk("mr_resp_data", resp_data, 32'd0);
    chk("mr_resp_status", {28'd0, resp_status}, 32'd0);
    chk("mr_grant", {30'd0, grant_id}, 32'd0);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_start", {31'd0, fpu_start}, 32'd0);
    chk("mr_op_a", fpu_op_a, 32'd0);
    chk("mr_op_b", fpu_op_b, 32'd0);
    tick();
    fpu_done = 1'b1; fpu_result = 32'hBAD0_0001; fpu_status = 4'd1;
    tick();
    fpu_done = 1'b0;
    rst = 1'b0;
    job4("post_rst", 0, 32'h3F00_0000, 32'h4000_0000, 1, 32'h0ABC_0000, 4'd0, 1'b1);
    req_valid = '0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
